nand_tdm_dmux: RTL and testbench
================================

Name: nand_tdm_dmux

Overview:
Receive-side demultiplexer for a time-division-multiplexed sample stream. The transmit side selects one of CHANNELS lanes per slot onto a shared WIDTH-bit bus. This block recovers the frame boundary from a sync marker, steers each slot into its lane register, and presents a complete, coherent frame with a one-cycle valid pulse. It sits between the serial TDM link and the parallel per-channel consumers.

Parameters:
- WIDTH, 8, bits per sample/slot
- CHANNELS, 4, slots per frame (>=1); derived CW = max(1, $clog2(CHANNELS)), width of slot index

Ports:
- clk, input, 1, rising-edge clock, sole clock domain
- rst, input, 1, synchronous active-high reset
- in_data, input, WIDTH, sample on shared TDM bus
- in_valid, input, 1, in_data carries a slot sample this cycle
- in_sync, input, 1, marks slot 0 of a frame; qualified by in_valid
- out_data, output, CHANNELS*WIDTH, last complete frame; channel k at [k*WIDTH +: WIDTH]
- out_valid, output, 1, one-cycle pulse: out_data just updated with a new frame
- frame_err, output, 1, one-cycle pulse: partial frame discarded due to early sync
- slot, output, CW, number of samples captured in current frame (next slot index)

Behaviour:
- Reset (clk edge with rst=1): state=HUNT, slot=0, shadow lanes=0, out_data=0, out_valid=0, frame_err=0. rst overrides all inputs. Reset mid-frame drops the partial frame with no out_valid and no frame_err.
- Accept = in_valid & rising clk edge. in_sync without in_valid is ignored. in_valid=0 cycles are gaps: no state change, slot held, unlimited length.
- HUNT: accept with in_sync=0 -> discarded, stay HUNT. Accept with in_sync=1 -> shadow[0]=in_data, slot=1, go RECV. If CHANNELS==1, the frame completes immediately (see completion) and the state stays HUNT.
- RECV, accept with in_sync=0 -> shadow[slot]=in_data, slot++. When this is slot CHANNELS-1 the frame completes: on that edge out_data <= shadow lanes 0..CHANNELS-2 concatenated with in_data in lane CHANNELS-1, out_valid=1 for the following cycle, slot=0, go HUNT.
- RECV, accept with in_sync=1 (early sync): frame_err=1 for the following cycle. The partial frame is discarded and out_data is unchanged. This sample is captured as the new slot 0 (shadow[0]=in_data, slot=1), stay RECV.
- Latency: out_valid and the new out_data are visible the cycle after the last slot is accepted. Back-to-back frames are supported: a sync accepted on the cycle immediately after completion starts the next frame with no dead cycle.
- out_data changes only on frame completion and holds otherwise. Partial frames never appear on out_data. out_valid and frame_err are never high for more than one consecutive cycle per event and are never both high.
- A sync sample arriving while in_valid=0 in RECV is ignored. No timeout applies.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset: hold rst 2 cycles with random inputs -> out_data=32'h0, out_valid=0, frame_err=0, slot=0 (WIDTH=8, CHANNELS=4 for all tests).
- Basic frame: accept sync+A0, then A1, A2, A3 on consecutive cycles -> one cycle after A3, out_valid=1 for exactly 1 cycle and out_data=32'hA3A2A1A0. slot reads 1, 2, 3, 0.
- Gaps and back-to-back frames: frame 10,20,30,40 with 3 idle cycles between samples, then sync+50,60,70,80 starting on the next cycle -> out_valid pulses twice, out_data=32'h40302010 then 32'h80706050, no frame_err.
- Early sync: sync+11, 22, then sync+55, 66, 77, 88 -> frame_err pulse 1 cycle after the second sync, no out_valid for the partial frame, then out_valid with out_data=32'h88776655.
- No sync: 8 accepts with in_sync=0 from HUNT -> no out_valid, out_data unchanged, slot=0. A sync with in_valid=0 also has no effect.
- Reset mid-frame: sync+01, 02, then rst 1 cycle, then full frame sync+C0, C1, C2, C3 -> a single out_valid with 32'hC3C2C1C0 and no frame_err.

Source files
------------

// File: rtl/nand_tdm_dmux.sv
// nand_tdm_dmux: receive-side TDM demultiplexer.
// Recovers the frame boundary from the sync marker, steers each slot into a
// shadow lane and publishes a complete frame on out_data with a one-cycle
// out_valid pulse. A sync arriving mid-frame discards the partial frame,
// pulses frame_err and restarts capture with that sample as slot 0.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_data    WIDTH-bit sample on the shared TDM bus
//   in_valid   in_data carries a slot sample this cycle
//   in_sync    marks slot 0 of a frame (qualified by in_valid)
//   out_data   last complete frame, channel k at [k*WIDTH +: WIDTH]
//   out_valid  one-cycle pulse, out_data just updated
//   frame_err  one-cycle pulse, partial frame dropped on early sync
//   slot       samples captured in the current frame (next slot index)
//
// state | meaning
// ------+-------------------------------------------------------------
// HUNT  | waiting for a sync sample; non-sync samples are dropped
// RECV  | frame in progress; slot holds the next lane to fill

module nand_tdm_dmux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      in_valid,
    input  logic                      in_sync,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      out_valid,
    output logic                      frame_err,
    output logic [CW-1:0]             slot
);

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);

    state_t                      state;
    logic [CHANNELS*WIDTH-1:0]   shadow;
    logic [CHANNELS*WIDTH-1:0]   frame_next;

    // Completed frame: captured lanes with the arriving sample in the top lane.
    always_comb begin
        frame_next = shadow;
        frame_next[(CHANNELS-1)*WIDTH +: WIDTH] = in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            slot      <= '0;
            shadow    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            if (in_valid) begin
                case (state)
                    HUNT: begin
                        if (in_sync) begin
                            shadow[0 +: WIDTH] <= in_data;
                            if (CHANNELS == 1) begin
                                // Single-lane frame completes on its sync sample.
                                out_data  <= frame_next;
                                out_valid <= 1'b1;
                                slot      <= '0;
                            end else begin
                                slot  <= CW'(1);
                                state <= RECV;
                            end
                        end
                    end
                    RECV: begin
                        if (in_sync) begin
                            // Early sync: drop partial frame, restart at slot 0.
                            frame_err          <= 1'b1;
                            shadow[0 +: WIDTH] <= in_data;
                            slot               <= CW'(1);
                        end else if (slot == LAST) begin
                            shadow[(CHANNELS-1)*WIDTH +: WIDTH] <= in_data;
                            out_data  <= frame_next;
                            out_valid <= 1'b1;
                            slot      <= '0;
                            state     <= HUNT;
                        end else begin
                            for (int k = 0; k < CHANNELS; k++) begin
                                if (slot == CW'(k))
                                    shadow[k*WIDTH +: WIDTH] <= in_data;
                            end
                            slot <= slot + CW'(1);
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nand_tdm_dmux.sv
// tb_nand_tdm_dmux: self-checking bench for nand_tdm_dmux (WIDTH=8, CHANNELS=4).
// A cycle model predicts pulses, slot and out_data; completed frames are
// queued and popped by a monitor when the DUT raises out_valid.

module tb_nand_tdm_dmux;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_sync;
    logic [31:0] out_data;
    logic        out_valid;
    logic        frame_err;
    logic [1:0]  slot;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    int          valid_seen = 0;
    int          err_seen   = 0;
    int          err_exp    = 0;

    // model state
    logic        m_recv = 1'b0;
    int          m_slot = 0;
    logic [31:0] m_shadow = '0;
    logic [31:0] m_out = '0;

    nand_tdm_dmux #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sync   (in_sync),
        .out_data  (out_data),
        .out_valid (out_valid),
        .frame_err (frame_err),
        .slot      (slot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard side: pop on every out_valid pulse.
    always @(negedge clk) begin
        if (out_valid) begin
            valid_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                chk("sb_frame", out_data, exp_q.pop_front());
            end
        end
        if (frame_err) err_seen++;
        if (out_valid && frame_err) chk("valid_and_err", 32'd1, 32'd0);
    end

    // One clock with given inputs; model updated, outputs checked #1 after edge.
    task automatic cyc(input logic r, input logic v, input logic s, input logic [7:0] d);
        logic ev;
        logic ee;
        rst = r; in_valid = v; in_sync = s; in_data = d;
        ev = 1'b0; ee = 1'b0;
        if (r) begin
            m_recv = 1'b0; m_slot = 0; m_shadow = '0; m_out = '0;
        end else if (v) begin
            if (!m_recv) begin
                if (s) begin
                    m_shadow[7:0] = d; m_slot = 1; m_recv = 1'b1;
                end
            end else if (s) begin
                ee = 1'b1; err_exp++;
                m_shadow[7:0] = d; m_slot = 1;
            end else begin
                m_shadow[m_slot*8 +: 8] = d;
                if (m_slot == 3) begin
                    m_out = m_shadow; ev = 1'b1; m_slot = 0; m_recv = 1'b0;
                    exp_q.push_back(m_shadow);
                end else begin
                    m_slot++;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
        chk("frame_err", {31'd0, frame_err}, {31'd0, ee});
        chk("out_data",  out_data, m_out);
        chk("slot",      {30'd0, slot}, 32'(m_slot));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sync = 1'b0; in_data = '0;

        // reset with random inputs
        for (int i = 0; i < 2; i++)
            cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        chk("reset_data", out_data, 32'h0);
        chk("reset_slot", {30'd0, slot}, 32'd0);

        // basic frame
        cyc(1'b0, 1'b1, 1'b1, 8'hA0);
        chk("basic_slot1", {30'd0, slot}, 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 8'hA1);
        chk("basic_slot2", {30'd0, slot}, 32'd2);
        cyc(1'b0, 1'b1, 1'b0, 8'hA2);
        chk("basic_slot3", {30'd0, slot}, 32'd3);
        cyc(1'b0, 1'b1, 1'b0, 8'hA3);
        chk("basic_data", out_data, 32'hA3A2A1A0);
        chk("basic_pulse", {31'd0, out_valid}, 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("basic_pulse_end", {31'd0, out_valid}, 32'd0);

        // gaps, then back-to-back frame
        cyc(1'b0, 1'b1, 1'b1, 8'h10); idle(3);
        cyc(1'b0, 1'b1, 1'b0, 8'h20); idle(3);
        cyc(1'b0, 1'b1, 1'b0, 8'h30); idle(3);
        cyc(1'b0, 1'b1, 1'b0, 8'h40);
        chk("gap_data", out_data, 32'h40302010);
        cyc(1'b0, 1'b1, 1'b1, 8'h50);
        cyc(1'b0, 1'b1, 1'b0, 8'h60);
        cyc(1'b0, 1'b1, 1'b0, 8'h70);
        cyc(1'b0, 1'b1, 1'b0, 8'h80);
        chk("b2b_data", out_data, 32'h80706050);
        idle(2);

        // early sync
        cyc(1'b0, 1'b1, 1'b1, 8'h11);
        cyc(1'b0, 1'b1, 1'b0, 8'h22);
        cyc(1'b0, 1'b1, 1'b1, 8'h55);
        chk("early_err", {31'd0, frame_err}, 32'd1);
        chk("early_hold", out_data, 32'h80706050);
        cyc(1'b0, 1'b1, 1'b0, 8'h66);
        chk("early_err_end", {31'd0, frame_err}, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 8'h77);
        cyc(1'b0, 1'b1, 1'b0, 8'h88);
        chk("early_data", out_data, 32'h88776655);
        idle(1);

        // no sync from HUNT, plus sync without valid
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 1'b1, 1'b0, 8'($urandom));
        cyc(1'b0, 1'b0, 1'b1, 8'hEE);
        chk("nosync_slot", {30'd0, slot}, 32'd0);
        chk("nosync_hold", out_data, 32'h88776655);

        // reset mid-frame
        cyc(1'b0, 1'b1, 1'b1, 8'h01);
        cyc(1'b0, 1'b1, 1'b0, 8'h02);
        cyc(1'b1, 1'b1, 1'b0, 8'h03);
        chk("midrst_data", out_data, 32'h0);
        cyc(1'b0, 1'b1, 1'b1, 8'hC0);
        cyc(1'b0, 1'b1, 1'b0, 8'hC1);
        cyc(1'b0, 1'b1, 1'b0, 8'hC2);
        cyc(1'b0, 1'b1, 1'b0, 8'hC3);
        chk("midrst_frame", out_data, 32'hC3C2C1C0);
        idle(3);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        chk("valid_count", 32'(valid_seen), 32'd5);
        chk("err_count", 32'(err_seen), 32'(err_exp));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
